// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: bus owner encoding and default parameters shared by the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {OWN_IDLE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} owner_e;
  localparam int ADDR_W_D      = 32;
  localparam int DATA_W_D      = 32;
  localparam int MAX_DMA_RUN_D = 4;
  localparam int CNT_W_D       = 16;
endpackage

// File: rtl/dmem_arb_rr.sv
// dmem_arb_rr: alternating-priority CPU/DMA grant with a cap on consecutive DMA wins while the CPU waits
module dmem_arb_rr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_DMA_RUN = MAX_DMA_RUN_D
) (
  input  logic clk,
  input  logic rst,
  input  logic i_cpu_req,
  input  logic i_dma_req,
  output logic o_cpu_gnt,
  output logic o_dma_gnt
);
  localparam int RUN_W = $clog2(MAX_DMA_RUN + 1);
  logic             r_prio_dma;
  logic [RUN_W-1:0] r_run_cnt;
  logic             w_run_max;
  assign w_run_max = r_run_cnt == RUN_W'(MAX_DMA_RUN);
  assign o_cpu_gnt = i_cpu_req & (~i_dma_req | w_run_max | ~r_prio_dma);
  assign o_dma_gnt = i_dma_req & ~o_cpu_gnt;
  // prio only moves on contended cycles; the run counter restarts whenever the CPU is not waiting
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_prio_dma <= 1'b0;
      r_run_cnt  <= '0;
    end else begin
      r_prio_dma <= (i_cpu_req & i_dma_req) ? o_cpu_gnt : r_prio_dma;
      r_run_cnt  <= (~i_cpu_req | o_cpu_gnt) ? '0 :
                    (o_dma_gnt & ~w_run_max) ? r_run_cnt + 1'b1 : r_run_cnt;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-cycle data memory between the CPU datapath and a DMA/loader port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_D,
  parameter int DATA_W      = DATA_W_D,
  parameter int MAX_DMA_RUN = MAX_DMA_RUN_D,
  parameter int CNT_W       = CNT_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        bus_owner,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              w_cpu_req, w_cpu_gnt, w_dma_gnt;
  owner_e            r_owner;
  logic [DATA_W-1:0] r_dma_rdata;
  logic              r_dma_rvalid;
  logic [CNT_W-1:0]  r_stall_cnt;
  assign w_cpu_req = cpu_mem_read | cpu_mem_write;
  dmem_arb_rr #(.MAX_DMA_RUN(MAX_DMA_RUN)) u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_cpu_req(w_cpu_req),
    .i_dma_req(dma_req),
    .o_cpu_gnt(w_cpu_gnt),
    .o_dma_gnt(w_dma_gnt)
  );
  // a CPU request with both strobes high is a store; the read strobe is ignored
  assign mem_addr   = w_cpu_gnt ? cpu_addr : w_dma_gnt ? dma_addr : '0;
  assign mem_wdata  = w_cpu_gnt ? cpu_wdata : w_dma_gnt ? dma_wdata : '0;
  assign mem_we     = (w_cpu_gnt & cpu_mem_write) | (w_dma_gnt & dma_we);
  assign mem_re     = (w_cpu_gnt & ~cpu_mem_write) | (w_dma_gnt & ~dma_we);
  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = w_cpu_req & ~w_cpu_gnt;
  assign dma_gnt    = w_dma_gnt;
  assign dma_rdata  = r_dma_rdata;
  assign dma_rvalid = r_dma_rvalid;
  assign bus_owner  = r_owner;
  assign stall_cnt  = r_stall_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_owner      <= OWN_IDLE;
      r_dma_rdata  <= '0;
      r_dma_rvalid <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_owner      <= w_cpu_gnt ? OWN_CPU : w_dma_gnt ? OWN_DMA : OWN_IDLE;
      r_dma_rvalid <= w_dma_gnt & ~dma_we;
      r_dma_rdata  <= (w_dma_gnt & ~dma_we) ? mem_rdata : r_dma_rdata;
      r_stall_cnt  <= r_stall_cnt + CNT_W'(cpu_stall & ~&r_stall_cnt);
    end
endmodule
